// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: runs a req/ack transaction with a
// variable-latency memory, stalls the pipeline until completion, flags errors.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] Wdata_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic [31:0] Rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        access_s;
  logic        stall_s;

  assign access_s = MemRead_i | MemWrite_i;
  assign stall_s  = ((state_q == IDLE) & access_s) | (state_q == REQ);

  // Next-state and transaction bookkeeping
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    err_d   = err_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          if (Addr_i[1:0] != 2'b00) begin
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            we_d    = MemWrite_i;
            addr_d  = {Addr_i[31:2], 2'b00};
            wdata_d = Wdata_i;
            wait_d  = 16'h0000;
            state_d = REQ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // An ack on the final timeout cycle still completes cleanly
        if (mem_ack_i) begin
          rdata_d = we_q ? 32'h0000_0000 : mem_rdata_i;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (wait_q == TMO_LAST) begin
          rdata_d = 32'h0000_0000;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 16'h0001;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating stall-cycle counter
  always_comb begin
    if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'h0000_0001;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q     <= IDLE;
      wait_q      <= 16'h0000;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      rdata_q     <= 32'h0000_0000;
      stall_cnt_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_req_o   = (state_q == REQ);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = stall_s;
  assign Rdata_o     = rdata_q;
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) & err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT = 4). Inputs change on the
// falling edge and outputs are checked 1 time unit later.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        req, we, stall, done, err;
  logic [31:0] maddr, mwdata, rd, scnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk_i(clk), .start_i(start), .MemRead_i(mem_read), .MemWrite_i(mem_write),
    .Addr_i(addr), .Wdata_i(wdata), .mem_ack_i(ack), .mem_rdata_i(rdata),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .stall_o(stall), .Rdata_o(rd), .done_o(done), .err_o(err), .stall_cnt_o(scnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic k, input logic [31:0] kd);
    @(negedge clk);
    mem_read = r; mem_write = w; addr = a; wdata = wd; ack = k; rdata = kd;
    #1;
  endtask

  initial begin
    // Reset state, with and without a pending access
    #2;
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_we", {31'h0, we}, 32'h0);
    chk("rst_addr", maddr, 32'h0);
    chk("rst_wdata", mwdata, 32'h0);
    chk("rst_rdata", rd, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    chk("rst_cnt", scnt, 32'h0);
    chk("rst_stall0", {31'h0, stall}, 32'h0);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("rst_stall1", {31'h0, stall}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    start = 1'b1;

    // Load 0x100, ack in 3rd REQ cycle
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("ld_stall_t", {31'h0, stall}, 32'h1);
    chk("ld_req_t", {31'h0, req}, 32'h0);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("ld_req1", {31'h0, req}, 32'h1);
    chk("ld_we", {31'h0, we}, 32'h0);
    chk("ld_addr", maddr, 32'h100);
    chk("ld_stall1", {31'h0, stall}, 32'h1);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("ld_req2", {31'h0, req}, 32'h1);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    chk("ld_req3", {31'h0, req}, 32'h1);
    chk("ld_stall3", {31'h0, stall}, 32'h1);
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
    chk("ld_done", {31'h0, done}, 32'h1);
    chk("ld_err", {31'h0, err}, 32'h0);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_req_off", {31'h0, req}, 32'h0);
    chk("ld_stall_done", {31'h0, stall}, 32'h0);
    chk("ld_cnt", scnt, 32'd4);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("ld_idle_done", {31'h0, done}, 32'h0);

    // Store 0x204, zero-wait ack
    drive(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b0, 32'h0);
    chk("st_stall_t", {31'h0, stall}, 32'h1);
    drive(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b1, 32'h55555555);
    chk("st_req", {31'h0, req}, 32'h1);
    chk("st_we", {31'h0, we}, 32'h1);
    chk("st_addr", maddr, 32'h204);
    chk("st_wdata", mwdata, 32'h12345678);
    drive(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b0, 32'h0);
    chk("st_done", {31'h0, done}, 32'h1);
    chk("st_rdata", rd, 32'h0);
    chk("st_stall_done", {31'h0, stall}, 32'h0);
    chk("st_cnt", scnt, 32'd6);

    // Misaligned load 0x103
    drive(1'b1, 1'b0, 32'h103, 32'h0, 1'b0, 32'h0);
    chk("mis_stall", {31'h0, stall}, 32'h1);
    chk("mis_req_t", {31'h0, req}, 32'h0);
    drive(1'b1, 1'b0, 32'h103, 32'h0, 1'b0, 32'h0);
    chk("mis_req", {31'h0, req}, 32'h0);
    chk("mis_done", {31'h0, done}, 32'h1);
    chk("mis_err", {31'h0, err}, 32'h1);
    chk("mis_cnt", scnt, 32'd7);

    // Ack on the 4th (last) REQ cycle: no error, data captured
    drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
      chk("ack4_req", {31'h0, req}, 32'h1);
    end
    drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'hA5A55A5A);
    chk("ack4_req4", {31'h0, req}, 32'h1);
    drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
    chk("ack4_done", {31'h0, done}, 32'h1);
    chk("ack4_err", {31'h0, err}, 32'h0);
    chk("ack4_rdata", rd, 32'hA5A55A5A);
    chk("ack4_cnt", scnt, 32'd12);

    // Timeout: REQ exactly 4 cycles, then error with Rdata 0
    drive(1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 32'h0);
      chk("tmo_req", {31'h0, req}, 32'h1);
    end
    drive(1'b1, 1'b0, 32'h304, 32'h0, 1'b0, 32'h0);
    chk("tmo_req_off", {31'h0, req}, 32'h0);
    chk("tmo_done", {31'h0, done}, 32'h1);
    chk("tmo_err", {31'h0, err}, 32'h1);
    chk("tmo_rdata", rd, 32'h0);
    chk("tmo_cnt", scnt, 32'd17);

    // Read and write both set: write wins, no error
    drive(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 1'b1, 32'h99999999);
    chk("rw_we", {31'h0, we}, 32'h1);
    chk("rw_wdata", mwdata, 32'h0BADF00D);
    drive(1'b1, 1'b1, 32'h400, 32'h0BADF00D, 1'b0, 32'h0);
    chk("rw_done", {31'h0, done}, 32'h1);
    chk("rw_err", {31'h0, err}, 32'h0);
    chk("rw_rdata", rd, 32'h0);
    chk("rw_cnt", scnt, 32'd19);

    // Spurious ack in IDLE
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    chk("spur_req", {31'h0, req}, 32'h0);
    chk("spur_done", {31'h0, done}, 32'h0);
    chk("spur_stall", {31'h0, stall}, 32'h0);
    chk("spur_rdata", rd, 32'h0);
    chk("spur_cnt", scnt, 32'd19);

    // Back-to-back loads
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b1, 32'h11111111);
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
    chk("b2b_done1", {31'h0, done}, 32'h1);
    chk("b2b_rdata1", rd, 32'h11111111);
    drive(1'b1, 1'b0, 32'h504, 32'h0, 1'b0, 32'h0);
    chk("b2b_stall", {31'h0, stall}, 32'h1);
    chk("b2b_req_gap", {31'h0, req}, 32'h0);
    drive(1'b1, 1'b0, 32'h504, 32'h0, 1'b1, 32'h22222222);
    chk("b2b_req2", {31'h0, req}, 32'h1);
    chk("b2b_addr2", maddr, 32'h504);
    drive(1'b1, 1'b0, 32'h504, 32'h0, 1'b0, 32'h0);
    chk("b2b_done2", {31'h0, done}, 32'h1);
    chk("b2b_rdata2", rd, 32'h22222222);
    chk("b2b_cnt", scnt, 32'd23);

    // Reset in the 2nd REQ cycle
    drive(1'b1, 1'b0, 32'h600, 32'hCAFE0000, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h600, 32'hCAFE0000, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 32'h600, 32'hCAFE0000, 1'b0, 32'h0);
    chk("mr_req_pre", {31'h0, req}, 32'h1);
    chk("mr_wdata_pre", mwdata, 32'hCAFE0000);
    start = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("mr_req", {31'h0, req}, 32'h0);
    chk("mr_addr", maddr, 32'h0);
    chk("mr_wdata", mwdata, 32'h0);
    chk("mr_rdata", rd, 32'h0);
    chk("mr_stall", {31'h0, stall}, 32'h0);
    chk("mr_cnt", scnt, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    start = 1'b1;
    drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    chk("mr_idle_accept", {31'h0, stall}, 32'h1);
    drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    chk("mr_new_req", {31'h0, req}, 32'h1);
    drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b1, 32'h77777777);
    drive(1'b1, 1'b0, 32'h700, 32'h0, 1'b0, 32'h0);
    chk("mr_new_done", {31'h0, done}, 32'h1);
    chk("mr_new_err", {31'h0, err}, 32'h0);
    chk("mr_new_rdata", rd, 32'h77777777);
    chk("mr_new_cnt", scnt, 32'd3);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
